mips_instr_encoder: RTL and testbench

Encoding counterpart of the main opcode decoder. Accepts instruction fields over a valid/ready interface, checks the opcode against the decoder's supported set, and packs a 32-bit MIPS word. Buffers the words in a small FIFO and writes them sequentially into instruction memory from a programmable base address. Used by the bench/boot loader to fill instruction memory before the single-cycle core runs.

---
 rtl/mips_instr_encoder.sv | 152 +++++++++++++++
 tb/tb_mips_instr_encoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// Packs MIPS instruction fields into 32-bit words, buffers them and streams them
// into instruction memory. Optional illegal-opcode counter: MIPS_ENC_ILLEGAL_CNT_EN.
module mips_instr_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_WORDS  = 256,
    parameter int ADDR_W     = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic                        last,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [5:0]                  opcode,
    input  logic [4:0]                  rs,
    input  logic [4:0]                  rt,
    input  logic [4:0]                  rd,
    input  logic [4:0]                  shamt,
    input  logic [5:0]                  funct,
    input  logic [15:0]                 imm,
    input  logic [25:0]                 target,
    output logic                        imem_we,
    input  logic                        imem_ready,
    output logic [ADDR_W-1:0]           imem_addr,
    output logic [31:0]                 imem_wdata,
    output logic                        illegal,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(MEM_WORDS):0]  count
`ifdef MIPS_ENC_ILLEGAL_CNT_EN
    ,
    output logic [7:0]                  illegal_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(MEM_WORDS) + 1;
    localparam logic [PTR_W:0]   DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] WORDS_L = CNT_W'(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_cnt;
    logic [CNT_W-1:0] accepted;
    logic [31:0]      enc;
    logic             legal, accept, push, pop, fifo_empty, start_load;

    // Supported set mirrors the main decoder: 0x00-0x0F plus the load/store group.
    always_comb begin
        legal = 1'b0;
        case (opcode)
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: legal = 1'b1;
            default: legal = (opcode[5:4] == 2'b00);
        endcase
    end

    always_comb begin
        enc = {opcode, rs, rt, imm};
        case (opcode)
            6'h00:        enc = {opcode, rs, rt, rd, shamt, funct};
            6'h02, 6'h03: enc = {opcode, target};
            6'h01:        enc = {opcode, rs, 5'd0, imm};
            6'h0F:        enc = {opcode, 5'd0, rt, imm};
            default:      enc = {opcode, rs, rt, imm};
        endcase
    end

    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = !fifo_empty && imem_ready;
    assign in_ready   = (state == LOAD) && ((fifo_cnt < DEPTH_L) || pop) && (accepted < WORDS_L);
    assign accept     = in_valid && in_ready;
    assign push       = accept && legal;
    assign start_load = start && ((state == IDLE) || (state == DONE));

    assign imem_we    = !fifo_empty;
    assign imem_wdata = fifo_empty ? 32'd0 : mem[rd_ptr];
    assign busy       = (state == LOAD) || (state == DRAIN);
    assign done       = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = LOAD;
            LOAD:  if (last || (accepted == WORDS_L)) state_nxt = DRAIN;
            DRAIN: if (fifo_empty) state_nxt = DONE;
            DONE:  if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Storage has no reset; occupancy tracking alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accepted  <= '0;
            count     <= '0;
            imem_addr <= '0;
            illegal   <= 1'b0;
        end else begin
            illegal <= accept && !legal;
            if (start_load) begin
                accepted  <= '0;
                count     <= '0;
                imem_addr <= {base_addr[ADDR_W-1:2], 2'b00};
            end else begin
                if (push) accepted <= accepted + CNT_W'(1);
                if (pop) begin
                    count     <= count + CNT_W'(1);
                    imem_addr <= imem_addr + ADDR_W'(4);
                end
            end
        end
    end

`ifdef MIPS_ENC_ILLEGAL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       illegal_cnt <= '0;
        else if (start_load)                           illegal_cnt <= '0;
        else if (accept && !legal && illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: default instance plus a MEM_WORDS=4 instance on shared inputs.
module tb_mips_instr_encoder;

    logic        clk = 1'b0, rst = 1'b1;
    logic        start = 1'b0, last = 1'b0, in_valid = 1'b0, imem_ready = 1'b0;
    logic [31:0] base_addr = '0;
    logic [5:0]  opcode = '0, funct = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;

    logic        in_ready, imem_we, illegal, busy, done;
    logic [31:0] imem_addr, imem_wdata;
    logic [8:0]  count;
    logic        in_ready4, imem_we4, illegal4, busy4, done4;
    logic [31:0] imem_addr4, imem_wdata4;
    logic [2:0]  count4;
`ifdef MIPS_ENC_ILLEGAL_CNT_EN
    logic [7:0]  illegal_cnt, illegal_cnt4;
`endif

    always #5 clk = ~clk;

    mips_instr_encoder dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .last(last),
        .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rs(rs), .rt(rt),
        .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .target(target),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .illegal(illegal), .busy(busy), .done(done), .count(count)
`ifdef MIPS_ENC_ILLEGAL_CNT_EN
        , .illegal_cnt(illegal_cnt)
`endif
    );

    mips_instr_encoder #(.FIFO_DEPTH(4), .MEM_WORDS(4), .ADDR_W(32)) dut4 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .last(last),
        .in_valid(in_valid), .in_ready(in_ready4), .opcode(opcode), .rs(rs), .rt(rt),
        .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .target(target),
        .imem_we(imem_we4), .imem_ready(imem_ready), .imem_addr(imem_addr4),
        .imem_wdata(imem_wdata4), .illegal(illegal4), .busy(busy4), .done(done4), .count(count4)
`ifdef MIPS_ENC_ILLEGAL_CNT_EN
        , .illegal_cnt(illegal_cnt4)
`endif
    );

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] word;
        logic        ill;
    } vec_t;

    vec_t tv[11];
    int   lj[9] = '{0, 1, 2, 3, 4, 5, 7, 8, 10};
    int   nvec = 0, nerr = 0;
    int   ill_seen = 0, w4 = 0;
    logic [31:0] wq_a[$], wq_d[$];

    // Write/illegal monitor; inputs change on negedge so posedge sampling is race-free.
    always @(posedge clk) begin
        if (!rst) begin
            if (imem_we && imem_ready) begin
                wq_a.push_back(imem_addr);
                wq_d.push_back(imem_wdata);
            end
            if (illegal) ill_seen++;
            if (imem_we4 && imem_ready) w4++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s: timed out", nm);
    endtask

    task automatic drive(input int i);
        opcode = tv[i].op; rs = tv[i].rs; rt = tv[i].rt; rd = tv[i].rd;
        shamt = tv[i].sh; funct = tv[i].fn; imm = tv[i].imm; target = tv[i].tgt;
        in_valid = 1'b1;
    endtask

    task automatic begin_session(input logic [31:0] b);
        base_addr = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wq_a.delete();
        wq_d.delete();
        ill_seen = 0;
        w4 = 0;
    endtask

    // Returns at the negedge after acceptance (cycle N+1).
    task automatic send(input int i, input bit with_last);
        bit acc = 1'b0;
        drive(i);
        for (int t = 0; t < 50 && !acc; t++) begin
            last = with_last && in_ready;
            @(posedge clk);
            acc = in_ready;
            @(negedge clk);
            last = 1'b0;
        end
        in_valid = 1'b0;
        if (!acc) timeout("send");
    endtask

    task automatic wait_done(input bit four);
        bit ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = four ? done4 : done;
        end
        if (!ok) timeout("wait_done");
    endtask

    initial begin
        int k;
        int w4_before;
        logic [31:0] hold_a, hold_d;

        tv[0]  = '{6'h00, 5'd1,  5'd2, 5'd3,  5'd0, 6'h20, 16'h0000, 26'h0,        32'h00221820, 1'b0};
        tv[1]  = '{6'h08, 5'd0,  5'd2, 5'd9,  5'd4, 6'h3F, 16'h0005, 26'h0,        32'h20020005, 1'b0};
        tv[2]  = '{6'h02, 5'd7,  5'd7, 5'd7,  5'd0, 6'h00, 16'hFFFF, 26'h0000010,  32'h08000010, 1'b0};
        tv[3]  = '{6'h23, 5'd29, 5'd4, 5'd0,  5'd0, 6'h00, 16'h0008, 26'h0,        32'h8FA40008, 1'b0};
        tv[4]  = '{6'h0F, 5'd5,  5'd1, 5'd31, 5'd0, 6'h00, 16'h1234, 26'h0,        32'h3C011234, 1'b0};
        tv[5]  = '{6'h01, 5'd3,  5'd7, 5'd0,  5'd0, 6'h00, 16'hFFFF, 26'h0,        32'h0460FFFF, 1'b0};
        tv[6]  = '{6'h3F, 5'd1,  5'd1, 5'd1,  5'd1, 6'h01, 16'h0101, 26'h0,        32'h0,        1'b1};
        tv[7]  = '{6'h2B, 5'd1,  5'd2, 5'd0,  5'd0, 6'h00, 16'h0010, 26'h0,        32'hAC220010, 1'b0};
        tv[8]  = '{6'h03, 5'd0,  5'd0, 5'd0,  5'd0, 6'h00, 16'h0000, 26'h3FFFFFF,  32'h0FFFFFFF, 1'b0};
        tv[9]  = '{6'h22, 5'd2,  5'd2, 5'd2,  5'd2, 6'h02, 16'h0202, 26'h0,        32'h0,        1'b1};
        tv[10] = '{6'h04, 5'd1,  5'd2, 5'd0,  5'd0, 6'h00, 16'hFFFE, 26'h0,        32'h1022FFFE, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);

        // Single R-type word: visible at N+1, then committed
        imem_ready = 1'b1;
        begin_session(32'h00400000);
        chk("t1_busy", busy, 1);
        send(0, 1'b0);
        chk("t1_we", imem_we, 1);
        chk("t1_wdata", imem_wdata, 32'h00221820);
        chk("t1_addr", imem_addr, 32'h00400000);
        @(negedge clk);
        chk("t1_count", count, 1);
        chk("t1_addr_inc", imem_addr, 32'h00400004);
        last = 1'b1;
        @(negedge clk);
        last = 1'b0;
        wait_done(1'b0);
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_count_end", count, 1);

        // Full table in one session; base low bits ignored; last rides with final bundle
        begin_session(32'h00400003);
        for (int i = 0; i < 11; i++) begin
            send(i, i == 10);
            chk($sformatf("tbl_illegal_%0d", i), illegal, tv[i].ill);
        end
        wait_done(1'b0);
        chk("tbl_nwrites", wq_d.size(), 9);
        for (int j = 0; j < 9; j++) begin
            chk($sformatf("tbl_data_%0d", j), wq_d[j], tv[lj[j]].word);
            chk($sformatf("tbl_addr_%0d", j), wq_a[j], 32'h00400000 + 32'(4 * j));
        end
        chk("tbl_count", count, 9);
        chk("tbl_ill_pulses", ill_seen, 2);
`ifdef MIPS_ENC_ILLEGAL_CNT_EN
        chk("tbl_illegal_cnt", illegal_cnt, 2);
`endif

        // Backpressure: FIFO fills, outputs hold, then drain in order
        imem_ready = 1'b0;
        begin_session(32'h00001000);
        k = 0;
        hold_a = '0;
        hold_d = '0;
        for (int c = 0; c < 10; c++) begin
            drive(lj[k]);
            @(posedge clk);
            if (in_ready) k++;
            @(negedge clk);
            if (c == 4) begin hold_a = imem_addr; hold_d = imem_wdata; end
        end
        in_valid = 1'b0;
        chk("bp_accepts", k, 4);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_we", imem_we, 1);
        chk("bp_addr", imem_addr, 32'h00001000);
        chk("bp_wdata", imem_wdata, tv[lj[0]].word);
        chk("bp_addr_stable", imem_addr, hold_a);
        chk("bp_wdata_stable", imem_wdata, hold_d);
        chk("bp_count", count, 0);
        imem_ready = 1'b1;
        while (k < 6) begin
            send(lj[k], k == 5);
            k++;
        end
        wait_done(1'b0);
        chk("bp_nwrites", wq_d.size(), 6);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("bp_data_%0d", j), wq_d[j], tv[lj[j]].word);
            chk($sformatf("bp_addr_%0d", j), wq_a[j], 32'h00001000 + 32'(4 * j));
        end
        chk("bp_count_end", count, 6);

        // MEM_WORDS=4 instance: stops accepting at 4, drains and finishes without last
        begin_session(32'h00002000);
        k = 0;
        for (int c = 0; c < 10; c++) begin
            drive(lj[k]);
            @(posedge clk);
            if (in_ready4) k++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mw_accepts", k, 4);
        chk("mw_in_ready", in_ready4, 0);
        wait_done(1'b1);
        chk("mw_count", count4, 4);
        chk("mw_done", done4, 1);
        chk("mw_writes", w4, 4);

        // Reset in the middle of the 2nd write of a fresh session
        imem_ready = 1'b0;
        begin_session(32'h00003000);
        send(lj[0], 1'b0);
        send(lj[1], 1'b0);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("mr_pre_count", count4, 1);
        chk("mr_pre_addr", imem_addr4, 32'h00003004);
        chk("mr_pre_we", imem_we4, 1);
        w4_before = w4;
        rst = 1'b1;
        #1;
        chk("mr_in_ready", in_ready4, 0);
        chk("mr_we", imem_we4, 0);
        chk("mr_addr", imem_addr4, 0);
        chk("mr_wdata", imem_wdata4, 0);
        chk("mr_illegal", illegal4, 0);
        chk("mr_busy", busy4, 0);
        chk("mr_done", done4, 0);
        chk("mr_count", count4, 0);
        @(negedge clk);
        rst = 1'b0;
        imem_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("mr_no_writes", w4, w4_before);
        chk("mr_we_after", imem_we4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
